// File: rtl/halftone_frame_sequencer_pkg.sv
// Shared types and constants for the error-diffusion halftone frame sequencer.
// Optional build macro HTPV_ERR_CLAMP_EN is consumed by halftone_pixel_unit.
package halftone_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int PIX_W   = 8;
    localparam int ERR_W   = 9;
    localparam int CPV_W   = 11;
    // Weighted error sum peaks at 16*255 = 4080, so 13 signed bits suffice.
    localparam int SUM_W   = 13;
    localparam int W_SHIFT = 4;

    localparam logic signed [SUM_W-1:0] W_L  = 13'sd7;
    localparam logic signed [SUM_W-1:0] W_UL = 13'sd1;
    localparam logic signed [SUM_W-1:0] W_U  = 13'sd5;
    localparam logic signed [SUM_W-1:0] W_UR = 13'sd3;

    localparam logic [PIX_W-1:0] DPV_WHITE = 8'd255;

    function automatic logic signed [SUM_W-1:0] masked_err(
        input logic signed [ERR_W-1:0] v,
        input logic                    en
    );
        return en ? SUM_W'(v) : '0;
    endfunction

endpackage

// File: rtl/halftone_pixel_unit.sv
// Combinational per-pixel error-diffusion step: weighted neighbour error, threshold, residual.
// Define HTPV_ERR_CLAMP_EN to saturate the stored residual to [-128,127].
module halftone_pixel_unit
    import halftone_frame_sequencer_pkg::*;
#(
    parameter int THRESH = 128
) (
    input  logic [PIX_W-1:0]        i_pix,
    input  logic signed [ERR_W-1:0] i_el,
    input  logic signed [ERR_W-1:0] i_eul,
    input  logic signed [ERR_W-1:0] i_eu,
    input  logic signed [ERR_W-1:0] i_eur,
    input  logic                    i_mask_l,
    input  logic                    i_mask_ul,
    input  logic                    i_mask_u,
    input  logic                    i_mask_ur,
    output logic                    o_white,
    output logic signed [ERR_W-1:0] o_err
);

    localparam logic signed [CPV_W-1:0] THRESH_CPV = CPV_W'(THRESH);
    localparam logic signed [CPV_W-1:0] WHITE_CPV  = CPV_W'(DPV_WHITE);

    logic signed [SUM_W-1:0] w_sum;
    logic signed [CPV_W-1:0] w_eav;
    logic signed [CPV_W-1:0] w_cpv;
    logic signed [CPV_W-1:0] w_err_full;

    assign w_sum = W_L  * masked_err(i_el,  i_mask_l)
                 + W_UL * masked_err(i_eul, i_mask_ul)
                 + W_U  * masked_err(i_eu,  i_mask_u)
                 + W_UR * masked_err(i_eur, i_mask_ur);

    // Arithmetic shift floors negative sums, which is what the diffusion kernel wants.
    assign w_eav      = CPV_W'(w_sum >>> W_SHIFT);
    assign w_cpv      = $signed({{(CPV_W-PIX_W){1'b0}}, i_pix}) + w_eav;
    assign o_white    = (w_cpv >= THRESH_CPV);
    assign w_err_full = w_cpv - (o_white ? WHITE_CPV : '0);

`ifdef HTPV_ERR_CLAMP_EN
    always_comb begin
        // NOTE: assign a default first in every always_comb so no path can infer a latch.
        o_err = ERR_W'(w_err_full);
        if (w_err_full > 11'sd127)
            o_err = 9'sd127;
        else if (w_err_full < -11'sd128)
            o_err = -9'sd128;
    end
`else
    assign o_err = ERR_W'(w_err_full);
`endif

endmodule

// File: rtl/halftone_frame_sequencer.sv
// Raster-order error-diffusion halftoner: one pixel per accepted beat, one packed row out per image row.
// Optional build macro HTPV_ERR_CLAMP_EN (see halftone_pixel_unit) saturates stored errors.
module halftone_frame_sequencer
    import halftone_frame_sequencer_pkg::*;
#(
    parameter int ROWS   = 6,
    parameter int COLS   = 8,
    parameter int THRESH = 128,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W = $clog2(COLS)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_go,
    input  logic             i_pix_valid,
    input  logic [PIX_W-1:0] i_pix_data,
    output logic             o_pix_ready,
    output logic             o_busy,
    output logic             o_row_valid,
    output logic [ROW_W-1:0] o_row_idx,
    output logic [COLS-1:0]  o_row_bits,
    output logic             o_done
);

    state_t r_state;
    state_t w_state_next;

    logic [ROW_W-1:0]        r_row;
    logic [COL_W-1:0]        r_col;
    logic signed [ERR_W-1:0] r_line [COLS];
    logic signed [ERR_W-1:0] r_el;
    logic signed [ERR_W-1:0] r_eul;
    logic [COLS-1:0]         r_shift;
    logic                    r_row_valid;
    logic [ROW_W-1:0]        r_row_idx;
    logic [COLS-1:0]         r_row_bits;

    logic                    w_accept;
    logic                    w_first_row;
    logic                    w_first_col;
    logic                    w_last_row;
    logic                    w_last_col;
    logic [COL_W-1:0]        w_col_nx;
    logic [COL_W-1:0]        w_bit_idx;
    logic signed [ERR_W-1:0] w_eu;
    logic signed [ERR_W-1:0] w_eur;
    logic                    w_white;
    logic signed [ERR_W-1:0] w_err;
    logic [COLS-1:0]         w_row_next;

    assign w_accept    = i_pix_valid && (r_state == ST_RUN);
    assign w_first_row = (r_row == '0);
    assign w_first_col = (r_col == '0);
    assign w_last_row  = (r_row == ROW_W'(ROWS - 1));
    assign w_last_col  = (r_col == COL_W'(COLS - 1));
    assign w_col_nx    = r_col + 1'b1;
    assign w_bit_idx   = COL_W'(COLS - 1) - r_col;

    assign w_eu  = r_line[r_col];
    assign w_eur = w_last_col ? '0 : r_line[w_col_nx];

    halftone_pixel_unit #(.THRESH(THRESH)) u_pixel (
        .i_pix     (i_pix_data),
        .i_el      (r_el),
        .i_eul     (r_eul),
        .i_eu      (w_eu),
        .i_eur     (w_eur),
        .i_mask_l  (!w_first_col),
        .i_mask_ul (!w_first_row && !w_first_col),
        .i_mask_u  (!w_first_row),
        .i_mask_ur (!w_first_row && !w_last_col),
        .o_white   (w_white),
        .o_err     (w_err)
    );

    always_comb begin
        w_row_next            = r_shift;
        w_row_next[w_bit_idx] = w_white;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_go) w_state_next = ST_RUN;
            ST_RUN:  if (w_accept && w_last_col && w_last_row) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_row       <= '0;
            r_col       <= '0;
            r_el        <= '0;
            r_eul       <= '0;
            r_shift     <= '0;
            r_row_valid <= 1'b0;
            r_row_idx   <= '0;
            r_row_bits  <= '0;
            // NOTE: the line buffer is small register storage, so it is reset like any other flop.
            for (int i = 0; i < COLS; i++)
                r_line[i] <= '0;
        end else begin
            r_row_valid <= 1'b0;
            if (w_accept) begin
                r_line[r_col] <= w_err;
                r_eul         <= w_eu;
                r_shift       <= w_row_next;
                if (w_last_col) begin
                    r_el        <= '0;
                    r_col       <= '0;
                    r_row       <= w_last_row ? '0 : r_row + 1'b1;
                    r_row_valid <= 1'b1;
                    r_row_idx   <= r_row;
                    r_row_bits  <= w_row_next;
                end else begin
                    r_el  <= w_err;
                    r_col <= w_col_nx;
                end
            end
        end
    end

    assign o_pix_ready = (r_state == ST_RUN);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_row_valid = r_row_valid;
    assign o_row_idx   = r_row_idx;
    assign o_row_bits  = r_row_bits;

endmodule

// File: tb/tb_halftone_frame_sequencer.sv
// Self-checking bench: directed and random frames against an arithmetic error-diffusion model.
module tb_halftone_frame_sequencer;

    localparam int ROWS   = 6;
    localparam int COLS   = 8;
    localparam int THRESH = 128;
    localparam int NPIX   = ROWS * COLS;

    logic            i_clock = 1'b0;
    logic            i_reset;
    logic            i_go;
    logic            i_pix_valid;
    logic [7:0]      i_pix_data;
    logic            o_pix_ready;
    logic            o_busy;
    logic            o_row_valid;
    logic [2:0]      o_row_idx;
    logic [COLS-1:0] o_row_bits;
    logic            o_done;

    int n_checks = 0;
    int n_fail   = 0;

    int              frame_pix [NPIX];
    logic [COLS-1:0] exp_rows  [ROWS];

    always #5 i_clock = ~i_clock;

    halftone_frame_sequencer #(.ROWS(ROWS), .COLS(COLS), .THRESH(THRESH)) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_go        (i_go),
        .i_pix_valid (i_pix_valid),
        .i_pix_data  (i_pix_data),
        .o_pix_ready (o_pix_ready),
        .o_busy      (o_busy),
        .o_row_valid (o_row_valid),
        .o_row_idx   (o_row_idx),
        .o_row_bits  (o_row_bits),
        .o_done      (o_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int floor_div16(input int s);
        if (s >= 0) return s / 16;
        return -((-s + 15) / 16);
    endfunction

    // Reference: Floyd-Steinberg style diffusion over the whole frame with plain integers.
    task automatic model_frame();
        int err [ROWS][COLS];
        int el, eul, eu, eur, s, cpv, e;
        bit white;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                el  = (c > 0)                  ? err[r][c-1]   : 0;
                eul = (r > 0 && c > 0)         ? err[r-1][c-1] : 0;
                eu  = (r > 0)                  ? err[r-1][c]   : 0;
                eur = (r > 0 && c < COLS - 1)  ? err[r-1][c+1] : 0;
                s     = 7 * el + eul + 5 * eu + 3 * eur;
                cpv   = frame_pix[r * COLS + c] + floor_div16(s);
                white = (cpv >= THRESH);
                e     = cpv - (white ? 255 : 0);
`ifdef HTPV_ERR_CLAMP_EN
                if (e > 127)  e = 127;
                if (e < -128) e = -128;
`endif
                err[r][c] = e;
                exp_rows[r][COLS-1-c] = white;
            end
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"},  o_busy,      0);
        chk({tag, "_ready"}, o_pix_ready, 0);
        chk({tag, "_rv"},    o_row_valid, 0);
        chk({tag, "_done"},  o_done,      0);
        chk({tag, "_bits"},  o_row_bits,  0);
        chk({tag, "_idx"},   o_row_idx,   0);
    endtask

    task automatic run_frame(input int valid_pct, input bit go_noise, input int abort_at);
        int k   = 0;
        int cyc = 0;
        bit acc;
        // Pixels offered in IDLE must not be consumed.
        repeat (3) begin
            i_pix_valid = 1'b1;
            i_pix_data  = 8'($urandom_range(255));
            @(posedge i_clock); #1;
            chk("idle_ready", o_pix_ready, 0);
            chk("idle_busy",  o_busy,      0);
        end
        i_pix_valid = 1'b0;
        i_go        = 1'b1;
        @(posedge i_clock); #1;
        i_go = 1'b0;
        chk("start_busy",  o_busy,      1);
        chk("start_ready", o_pix_ready, 1);
        while (k < NPIX && cyc < 2000) begin
            acc         = ($urandom_range(99) < valid_pct);
            i_pix_valid = acc;
            i_pix_data  = acc ? 8'(frame_pix[k]) : 8'($urandom_range(255));
            i_go        = go_noise ? 1'($urandom_range(1)) : 1'b0;
            @(posedge i_clock); #1;
            cyc++;
            if (acc) k++;
            if (acc && (k % COLS == 0)) begin
                chk("row_valid", o_row_valid, 1);
                chk("row_bits",  o_row_bits,  exp_rows[k/COLS-1]);
                chk("row_idx",   o_row_idx,   k / COLS - 1);
            end else begin
                chk("row_quiet", o_row_valid, 0);
            end
            if (k == NPIX) begin
                chk("done_pulse", o_done,      1);
                chk("done_busy",  o_busy,      1);
                chk("done_ready", o_pix_ready, 0);
            end else begin
                chk("run_done",  o_done,      0);
                chk("run_ready", o_pix_ready, 1);
            end
            if (abort_at >= 0 && acc && k == abort_at) begin
                i_go = 1'b0;
                i_reset = 1'b0;
                #1;
                reset_checks("abort");
                @(posedge i_clock); #1;
                i_reset = 1'b1;
                i_pix_valid = 1'b0;
                repeat (3) begin
                    @(posedge i_clock); #1;
                    chk("post_abort_rv",   o_row_valid, 0);
                    chk("post_abort_done", o_done,      0);
                    chk("post_abort_busy", o_busy,      0);
                end
                return;
            end
        end
        if (k < NPIX) begin
            n_checks++;
            n_fail++;
            $error("FAIL frame_timeout: observed %0d beats expected %0d", k, NPIX);
        end
        // go during DONE is ignored; DONE returns to IDLE unconditionally.
        i_go        = go_noise;
        i_pix_valid = 1'b1;
        i_pix_data  = 8'($urandom_range(255));
        @(posedge i_clock); #1;
        i_go        = 1'b0;
        i_pix_valid = 1'b0;
        chk("idle_busy_after",  o_busy,      0);
        chk("idle_done_after",  o_done,      0);
        chk("idle_rv_after",    o_row_valid, 0);
        chk("idle_ready_after", o_pix_ready, 0);
        chk("row_bits_hold",    o_row_bits,  exp_rows[ROWS-1]);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) frame_pix[i] = $urandom_range(255);
    endtask

    initial begin
        i_reset     = 1'b0;
        i_go        = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_data  = 8'h00;
        #12;
        reset_checks("reset");
        i_reset = 1'b1;
        @(posedge i_clock); #1;

        // All white: no error ever diffuses.
        for (int i = 0; i < NPIX; i++) frame_pix[i] = 255;
        for (int r = 0; r < ROWS; r++) exp_rows[r] = 8'hFF;
        run_frame(100, 1'b0, -1);

        // Half-split blocks, flipping halfway down the frame.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                frame_pix[r*COLS+c] = ((r < 3) == (c < 4)) ? 255 : 0;
        for (int r = 0; r < ROWS; r++) exp_rows[r] = (r < 3) ? 8'hF0 : 8'h0F;
        run_frame(100, 1'b0, -1);

        // Ramp on row 0 exercises floor shifts of negative sums.
        fill_random();
        for (int c = 0; c < COLS; c++) frame_pix[c] = 31 + 32 * c;
        model_frame();
        exp_rows[0] = 8'h2F;
        run_frame(100, 1'b0, -1);

        // All black with random stalls.
        for (int i = 0; i < NPIX; i++) frame_pix[i] = 0;
        for (int r = 0; r < ROWS; r++) exp_rows[r] = 8'h00;
        run_frame(50, 1'b0, -1);

        // Random content, stalls and stray go pulses.
        fill_random();
        model_frame();
        run_frame(70, 1'b1, -1);

        // Abort mid-frame, then a clean frame must still be correct.
        fill_random();
        model_frame();
        run_frame(100, 1'b0, 20);
        fill_random();
        model_frame();
        run_frame(80, 1'b0, -1);

        for (int f = 0; f < 3; f++) begin
            fill_random();
            model_frame();
            run_frame(60 + 10 * f, 1'(f & 1), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/halftone_frame_sequencer.md
Name: halftone_frame_sequencer

Overview:
Sequential controller that halftones a ROWS x COLS frame of 8-bit grey pixels into 1-bit halftone pixel values (HTPV) using error diffusion. It sequences one shared per-pixel datapath across the frame in raster order, one pixel per accepted beat. It keeps the previous row's errors in a line buffer and emits one packed HTPV row per completed image row. It is the sequential counterpart of the combinational 6x8 image converter.

Parameters:
ROWS, 6, image rows per frame
COLS, 8, pixels per row (minimum 2)
THRESH, 128, CPV at or above this maps to white (255)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
go  in  1  start-of-frame request, sampled in IDLE only
pix_valid  in  1  pix_data holds a valid pixel
pix_data  in  8  unsigned grey pixel, raster order
pix_ready  out  1  sequencer accepts the pixel this cycle
busy  out  1  frame in progress
row_valid  out  1  one-cycle pulse: row_bits is complete
row_idx  out  clog2(ROWS)  row number of row_bits, 0-based
row_bits  out  COLS  HTPV row; MSB = column 0 (leftmost), 1 = white
done  out  1  one-cycle pulse after the last row

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; line buffer, error registers and counters cleared. Reset mid-frame abandons the frame with no partial row output.
- States: IDLE -> RUN on go=1. RUN -> DONE after pixel (ROWS-1, COLS-1) is accepted. DONE -> IDLE unconditionally after one cycle.
- done=1 for exactly the DONE cycle. busy=1 in RUN and DONE. go is ignored in RUN and DONE.
- pix_ready = (state==RUN), combinational. A beat is accepted when pix_valid & pix_ready. Pixels presented in IDLE are not consumed.
- Per accepted pixel at (r,c), computed in the same cycle by the datapath:
  - E_av = (7*eL + 1*eUL + 5*eU + 3*eUR) >>> 4, using an arithmetic (floor) shift.
  - CPV = pix_data + E_av (signed, 11-bit internal).
  - DPV = (CPV >= THRESH) ? 255 : 0.
  - err = CPV - DPV, stored as 9-bit signed (range -255..255).
- Neighbours: eL = error of (r,c-1); eUL, eU, eUR = errors of (r-1,c-1), (r-1,c), (r-1,c+1).
- Borders: any neighbour outside the frame contributes 0. This covers row 0, column 0, column COLS-1, and the first frame after each IDLE.
- Line buffer: COLS x 9 bits. Read buf[c] and buf[c+1], then write buf[c]=err in the same cycle. The old buf[c] is registered as eUL for column c+1. At c=0, eUL=0.
- Bit (c) of the row shift register takes (DPV==255). On acceptance of c=COLS-1:
  - row_valid pulses next cycle with row_bits and row_idx=r.
  - row_bits holds its value until the next row_valid.
  - eL clears and the column counter wraps to 0.
- Latency: row_valid follows the last pixel of its row by 1 cycle. done follows the final row_valid in the same cycle.
- Stalls (pix_valid=0) freeze all state. No output backpressure.

Optional Feature:
HTPV_ERR_CLAMP_EN
- Defined: err is saturated to [-128,127] before it is stored in eL and the line buffer. This limits error streaking.
- Undefined: the full 9-bit error is stored and no clamp logic is present.

Decomposition:
- Shared package: state encoding (IDLE, RUN, DONE); weights 7/1/5/3; weight shift 4; PIX_W=8; ERR_W=9; DPV_WHITE=255.
- Sub-module halftone_pixel_unit: purely combinational. Inputs are pixel, eL, eUL, eU, eUR and the border masks. Outputs are the DPV bit and err. The clamp option lives inside it.

Test Plan:
- Reset, then go with 48 pixels of 255 -> six row_valid pulses, row_bits=8'hFF, row_idx 0..5, done one cycle after row 5.
- Frame: rows 0-2 = {255 x4, 0 x4}, rows 3-5 = {0 x4, 255 x4} -> rows 0-2 = 8'hF0, rows 3-5 = 8'h0F, all errors 0.
- Row 0 = 31,63,95,127,159,191,223,255 -> row_bits=8'h2F (intermediate err 31,76,-127,71,-65,-93,-73,-32).
- pix_valid toggled randomly with a constant 0 frame -> pix_ready high only in RUN, output 8'h00 every row, exactly 48 beats consumed.
- go pulsed during RUN -> ignored. pixels during IDLE -> pix_ready=0, not consumed.
- reset driven low after 20 beats -> all outputs 0 immediately, no row_valid/done. The next go produces a correct full frame.
